// File: rtl/sonar_pkg.sv
// sonar_pkg: shared state encoding, protocol bytes, sensor count and the round-robin picker for sonar_scheduler
package sonar_pkg;
  localparam int NUM_SENS = 4;
  typedef logic [2:0] state_t;
  // DIG0..WAIT_CR are consecutive so a good digit advances with state + 1
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_TRIG    = 3'd1;
  localparam state_t S_WAIT_R  = 3'd2;
  localparam state_t S_DIG0    = 3'd3;
  localparam state_t S_DIG1    = 3'd4;
  localparam state_t S_DIG2    = 3'd5;
  localparam state_t S_WAIT_CR = 3'd6;
  localparam state_t S_PUBLISH = 3'd7;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [15:0] ERR_RANGE = 16'h0FFF;
  // First set bit of mask at or after start, wrapping; returns start when mask is empty
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] id;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      id = start + 2'(i);
      if (mask[id]) rr_pick = id;
    end
  endfunction
endpackage

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin sonar ranging sequencer; triggers one sensor at a time, parses its "Rddd\r" reply
//   clock, reset_n      : system clock, synchronous active-low reset
//   enable, sensor_en   : run the continuous schedule / per-sensor participation mask
//   byte_data/ready     : bytes from the shared UART receiver
//   trig                : one-hot trigger pulse to the selected sensor
//   result_*            : valid/ready handshake carrying id, BCD range and error flag
//   busy                : high whenever the scheduler is not idle
module sonar_scheduler #(
  parameter int NUM_SENS    = sonar_pkg::NUM_SENS,
  parameter int TRIG_CYC    = 1000,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_SENS-1:0] sensor_en,
  input  logic [7:0]          byte_data,
  input  logic                byte_ready,
  output logic [NUM_SENS-1:0] trig,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [1:0]          result_id,
  output logic [15:0]         result_range,
  output logic                result_err,
  output logic                busy
);
  import sonar_pkg::*;
  localparam int TW = $clog2(TRIG_CYC + 1);
  localparam int OW = $clog2(TIMEOUT_CYC + 1);
  state_t state;
  logic [1:0] cur_id;
  logic [TW-1:0] trig_cnt;
  logic [OW-1:0] tmo_cnt;
  logic [3:0] hund, tens, units, digit;
  logic in_meas, tmo_hit, is_digit, any_en;
  always_comb begin
    any_en = |sensor_en;
    in_meas = state inside {S_TRIG, S_WAIT_R, S_DIG0, S_DIG1, S_DIG2, S_WAIT_CR};
    tmo_hit = in_meas && tmo_cnt == OW'(TIMEOUT_CYC - 1);
    is_digit = byte_data >= ASCII_0 && byte_data <= ASCII_9;
    digit = 4'(byte_data - ASCII_0);
  end
  assign trig = state == S_TRIG ? NUM_SENS'(1) << cur_id : '0;
  assign result_valid = state == S_PUBLISH;
  assign result_id = cur_id;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cur_id <= '0;
      trig_cnt <= '0;
      tmo_cnt <= '0;
      hund <= '0;
      tens <= '0;
      units <= '0;
      result_range <= '0;
      result_err <= 1'b0;
    end else begin
      if (in_meas) tmo_cnt <= tmo_cnt + 1'b1;
      // the timeout overrides any byte or trigger-end event in the same cycle
      if (tmo_hit) begin
        state <= S_PUBLISH;
        result_range <= ERR_RANGE;
        result_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (enable && any_en) begin
            cur_id <= rr_pick(sensor_en, cur_id);
            trig_cnt <= '0;
            tmo_cnt <= '0;
            state <= S_TRIG;
          end
          S_TRIG: begin
            trig_cnt <= trig_cnt + 1'b1;
            if (trig_cnt == TW'(TRIG_CYC - 1)) state <= S_WAIT_R;
          end
          S_WAIT_R: if (byte_ready && byte_data == ASCII_R) state <= S_DIG0;
          S_DIG0, S_DIG1, S_DIG2: if (byte_ready) begin
            if (!is_digit) begin
              state <= S_PUBLISH;
              result_range <= ERR_RANGE;
              result_err <= 1'b1;
            end else begin
              if (state == S_DIG0) hund <= digit;
              if (state == S_DIG1) tens <= digit;
              if (state == S_DIG2) units <= digit;
              state <= state + 3'd1;
            end
          end
          S_WAIT_CR: if (byte_ready) begin
            state <= S_PUBLISH;
            result_err <= byte_data != ASCII_CR;
            result_range <= byte_data == ASCII_CR ? {4'h0, hund, tens, units} : ERR_RANGE;
          end
          default: if (result_ready) begin
            if (any_en) cur_id <= rr_pick(sensor_en, cur_id + 2'd1);
            trig_cnt <= '0;
            tmo_cnt <= '0;
            state <= enable && any_en ? S_TRIG : S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed and randomized frames checked against a behavioural scheduler model
module tb_sonar_scheduler;
  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, byte_ready = 1'b0, result_ready = 1'b0;
  logic [3:0] sensor_en = '0;
  logic [7:0] byte_data = '0;
  logic [3:0] trig;
  logic result_valid, result_err, busy;
  logic [1:0] result_id;
  logic [15:0] result_range;
  int total = 0, bad = 0, cyc = 0, cur_model = 0, last_id = 0;
  logic [7:0] fq[$];
  logic [3:0] m;
  sonar_scheduler #(.NUM_SENS(4), .TRIG_CYC(4), .TIMEOUT_CYC(200)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sensor_en(sensor_en),
    .byte_data(byte_data), .byte_ready(byte_ready), .trig(trig),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_range(result_range), .result_err(result_err), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic int pick(input logic [3:0] mk, input int from);
    for (int k = 0; k < 4; k++) if (mk[(from + k) % 4]) return (from + k) % 4;
    return from % 4;
  endfunction
  // frame outcome from the protocol rules: index of the byte that ends the frame (-1 = timeout), error, range
  function automatic void model(input logic [7:0] q[$], output int term, output logic err, output logic [15:0] rng);
    int st;
    logic [3:0] d[3];
    st = 0;
    term = -1;
    err = 1'b1;
    rng = 16'h0FFF;
    d = '{4'h0, 4'h0, 4'h0};
    foreach (q[i]) begin
      if (st == 0) begin
        if (q[i] == 8'h52) st = 1;
      end else if (st <= 3) begin
        if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
          d[st-1] = 4'(q[i] - 8'h30);
          st++;
        end else begin
          term = i;
          return;
        end
      end else begin
        term = i;
        err = q[i] != 8'h0D;
        rng = err ? 16'h0FFF : {4'h0, d[0], d[1], d[2]};
        return;
      end
    end
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic setq(input string s);
    fq.delete();
    for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
  endtask
  task automatic frame(input int hold, input int drop_at, input int rst_at);
    int id, term, n, t0;
    logic err;
    logic [15:0] rng;
    logic [19:0] snap;
    id = pick(sensor_en, cur_model);
    n = 0;
    while (trig == 4'd0 && n < 50) begin tick; n++; end
    t0 = cyc;
    chk("trig_sel", trig, 32'(1) << id);
    chk("busy_meas", busy, 1);
    n = 0;
    while (trig != 4'd0 && n < 50) begin tick; n++; end
    chk("trig_width", n, 4);
    model(fq, term, err, rng);
    foreach (fq[i]) begin
      byte_data = fq[i];
      byte_ready = 1'b1;
      tick;
      byte_ready = 1'b0;
      if (i == rst_at) begin
        reset_n = 1'b0;
        tick;
        chk("reset_outs", {trig, result_valid, result_id, result_range, result_err, busy}, 0);
        reset_n = 1'b1;
        cur_model = 0;
        return;
      end
      if (i == drop_at) enable = 1'b0;
      chk("valid_lat", result_valid, i == term);
      if (i == term) break;
      tick;
    end
    if (term < 0) begin
      n = 0;
      while (!result_valid && n < 400) begin tick; n++; end
      chk("tmo_cycles", cyc - t0, 200);
    end
    chk("res_id", result_id, id);
    chk("res_range", result_range, rng);
    chk("res_err", result_err, err);
    snap = {result_valid, result_id, result_range, result_err};
    repeat (hold) begin
      tick;
      chk("hold_stable", {result_valid, result_id, result_range, result_err}, snap);
      chk("hold_notrig", trig, 0);
    end
    last_id = id;
  endtask
  task automatic accept(input logic [3:0] mk, input logic en);
    sensor_en = mk;
    enable = en;
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    chk("valid_drop", result_valid, 0);
    if (mk != 4'd0) cur_model = pick(mk, last_id + 1);
  endtask
  initial begin
    repeat (3) tick;
    chk("reset_state", {trig, result_valid, result_id, result_range, result_err, busy}, 0);
    reset_n = 1'b1;
    repeat (2) tick;
    chk("idle_disabled", busy, 0);
    sensor_en = 4'b1111;
    enable = 1'b1;
    setq("R123\015");
    frame(0, -1, -1);
    accept(4'b1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      setq("R045\015");
      frame(0, -1, -1);
      accept(4'b1010, 1'b1);
    end
    fq.delete();
    frame(0, -1, -1);
    accept(4'b1111, 1'b1);
    setq("R1A5\015");
    frame(0, -1, -1);
    accept(4'b1111, 1'b1);
    setq("R999X");
    frame(0, -1, -1);
    accept(4'b1111, 1'b1);
    setq("xyR007\015");
    frame(0, -1, -1);
    accept(4'b1111, 1'b1);
    setq("R555\015");
    frame(10, -1, -1);
    accept(4'b1111, 1'b1);
    setq("R426\015");
    frame(0, 1, -1);
    accept(4'b1111, 1'b0);
    repeat (5) begin
      tick;
      chk("idle_after_drop", {busy, trig}, 0);
    end
    enable = 1'b1;
    setq("R12");
    frame(0, -1, 1);
    setq("R321\015");
    frame(0, -1, -1);
    accept(4'b1111, 1'b1);
    for (int f = 0; f < 25; f++) begin
      fq.delete();
      repeat ($urandom_range(0, 2)) fq.push_back(8'($urandom_range(32, 126)));
      fq.push_back(8'h52);
      repeat (3) fq.push_back(8'(8'h30 + $urandom_range(0, 9)));
      fq.push_back(8'h0D);
      if ($urandom_range(0, 3) == 0) fq[$urandom_range(0, fq.size() - 1)] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) void'(fq.pop_back());
      frame($urandom_range(0, 2), -1, -1);
      do m = 4'($urandom); while (m == 4'd0);
      accept(m, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
